// File: rtl/oled_digit_canvas_if.sv
// Bundle of pixel-index, mouse and control signals shared by the canvas and its host.
// The master drives coordinates and buttons; the canvas returns pixels and decode results.
interface oled_digit_canvas_if #(
  parameter int NUM_DIGITS = 2
);
  logic [6:0]              x;
  logic [5:0]              y;
  logic [6:0]              mouse_x;
  logic [5:0]              mouse_y;
  logic                    mouse_left;
  logic                    submit;
  logic                    clear;
  logic [15:0]             oled_data;
  logic [7*NUM_DIGITS-1:0] seg_state;
  logic [4*NUM_DIGITS-1:0] digit_value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    result_valid;

  modport master (
    output x, y, mouse_x, mouse_y, mouse_left, submit, clear,
    input  oled_data, seg_state, digit_value, digit_valid, result_valid
  );

  modport slave (
    input  x, y, mouse_x, mouse_y, mouse_left, submit, clear,
    output oled_data, seg_state, digit_value, digit_valid, result_valid
  );
endinterface

// File: rtl/oled_digit_canvas.sv
// Mouse-editable multi-digit seven-segment canvas: click-to-toggle segments, BCD decode,
// submit/clear lock state machine and a registered RGB565 pixel for the OLED scan.
module oled_digit_canvas #(
  parameter int NUM_DIGITS  = 2,
  parameter int DIGIT_X0    = 8,
  parameter int DIGIT_Y0    = 3,
  parameter int DIGIT_PITCH = 26,
  parameter int SEG_LEN     = 20,
  parameter int SEG_THK     = 3,
  parameter int BLINK_DIV   = 3125000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  oled_digit_canvas_if.slave    bus
);
  localparam int W        = SEG_LEN;
  localparam int T        = SEG_THK;
  localparam int ERR_LOAD = 4 * BLINK_DIV;
  localparam int ERR_W    = $clog2(ERR_LOAD + 1);
  localparam int BLK_W    = $clog2(BLINK_DIV + 1);

  typedef enum logic [1:0] {EDIT, LOCKED, ERROR} state_t;

  state_t                  state_reg;
  logic [1:0]              sync_reg;
  logic                    prev_reg;
  logic                    loaded_reg;
  logic                    armed_reg;
  logic [7*NUM_DIGITS-1:0] seg_reg;
  logic [ERR_W-1:0]        err_cnt_reg;
  logic [BLK_W-1:0]        blink_cnt_reg;
  logic                    blink_on_reg;
  logic                    result_valid_reg;
  logic [15:0]             oled_reg;
  logic [15:0]             oled_next;
  logic [3:0]              value_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   valid_reg;

  logic                    click_rise;
  logic                    mouse_on;
  logic                    click_hit;
  logic [7*NUM_DIGITS-1:0] click_mask;
  logic [6:0]              click_cov;
  logic [6:0]              pix_cov;
  logic                    pix_found;

  // Segments covering a point relative to a digit origin, one bit per segment a..g.
  function automatic logic [6:0] seg_cover(input int u, input int v);
    logic [6:0] c;
    c[0] = (u >= 0)     && (u <= W) && (v >= 0)           && (v <= T - 1);
    c[1] = (u >= W-T+1) && (u <= W) && (v >= 0)           && (v <= W);
    c[2] = (u >= W-T+1) && (u <= W) && (v >= W)           && (v <= 2*W);
    c[3] = (u >= 0)     && (u <= W) && (v >= 2*W-T+1)     && (v <= 2*W);
    c[4] = (u >= 0)     && (u <= T-1) && (v >= W)         && (v <= 2*W);
    c[5] = (u >= 0)     && (u <= T-1) && (v >= 0)         && (v <= W);
    c[6] = (u >= 0)     && (u <= W) && (v >= W - T/2)     && (v <= W - T/2 + T - 1);
    return c;
  endfunction

  // {valid, value}; alternate 6/7/9 glyphs accepted.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:        return 5'h10;
      7'h06:        return 5'h11;
      7'h5B:        return 5'h12;
      7'h4F:        return 5'h13;
      7'h66:        return 5'h14;
      7'h6D:        return 5'h15;
      7'h7D, 7'h7C: return 5'h16;
      7'h07, 7'h27: return 5'h17;
      7'h7F:        return 5'h18;
      7'h6F, 7'h67: return 5'h19;
      default:      return 5'h0F;
    endcase
  endfunction

  // A button held through reset must be seen released before its rise can count.
  assign click_rise = sync_reg[1] & ~prev_reg & armed_reg;
  assign mouse_on   = (bus.mouse_x <= 7'd95);

  always_comb begin
    click_hit  = 1'b0;
    click_mask = '0;
    click_cov  = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (!click_hit) begin
        click_cov = seg_cover(int'(bus.mouse_x) - (DIGIT_X0 + d*DIGIT_PITCH),
                              int'(bus.mouse_y) - DIGIT_Y0);
        if (click_cov != 7'd0) begin
          click_hit = 1'b1;
          click_mask[7*d +: 7] = click_cov & (~click_cov + 7'd1);
        end
      end
    end
  end

  always_comb begin
    oled_next = 16'h0000;
    pix_found = 1'b0;
    pix_cov   = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (!pix_found) begin
        pix_cov = seg_cover(int'(bus.x) - (DIGIT_X0 + d*DIGIT_PITCH), int'(bus.y) - DIGIT_Y0);
        if (pix_cov != 7'd0) begin
          pix_found = 1'b1;
          if ((pix_cov & seg_reg[7*d +: 7]) != 7'd0) begin
            case (state_reg)
              LOCKED:  oled_next = 16'h07E0;
              ERROR:   oled_next = valid_reg[d] ? 16'hFFFF : (blink_on_reg ? 16'hF800 : 16'h0000);
              default: oled_next = 16'hFFFF;
            endcase
          end else begin
            oled_next = 16'h2104;
          end
        end
      end
    end
    if (mouse_on && bus.x == bus.mouse_x && bus.y == bus.mouse_y)
      oled_next = 16'hF800;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= EDIT;
      sync_reg         <= '0;
      prev_reg         <= 1'b0;
      loaded_reg       <= 1'b0;
      armed_reg        <= 1'b0;
      seg_reg          <= '0;
      err_cnt_reg      <= '0;
      blink_cnt_reg    <= '0;
      blink_on_reg     <= 1'b0;
      result_valid_reg <= 1'b0;
      oled_reg         <= 16'h0000;
    end else begin
      sync_reg   <= {sync_reg[0], bus.mouse_left};
      prev_reg   <= sync_reg[1];
      loaded_reg <= 1'b1;
      armed_reg  <= armed_reg | (loaded_reg & ~sync_reg[0]);
      oled_reg   <= oled_next;
      if (bus.clear) begin
        state_reg        <= EDIT;
        seg_reg          <= '0;
        err_cnt_reg      <= '0;
        blink_cnt_reg    <= '0;
        blink_on_reg     <= 1'b0;
        result_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          EDIT: begin
            if (bus.submit) begin
              if (&valid_reg) begin
                state_reg        <= LOCKED;
                result_valid_reg <= 1'b1;
              end else begin
                state_reg     <= ERROR;
                err_cnt_reg   <= ERR_W'(ERR_LOAD);
                blink_cnt_reg <= BLK_W'(BLINK_DIV);
                blink_on_reg  <= 1'b1;
              end
            end else if (click_rise && click_hit && mouse_on) begin
              seg_reg <= seg_reg ^ click_mask;
            end
          end
          ERROR: begin
            err_cnt_reg <= err_cnt_reg - ERR_W'(1);
            if (err_cnt_reg == ERR_W'(1)) begin
              state_reg     <= EDIT;
              blink_cnt_reg <= '0;
              blink_on_reg  <= 1'b0;
            end else if (blink_cnt_reg == BLK_W'(1)) begin
              blink_cnt_reg <= BLK_W'(BLINK_DIV);
              blink_on_reg  <= ~blink_on_reg;
            end else begin
              blink_cnt_reg <= blink_cnt_reg - BLK_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value_reg[gi] <= 4'hF;
        valid_reg[gi] <= 1'b0;
      end else begin
        {valid_reg[gi], value_reg[gi]} <= decode(seg_reg[7*gi +: 7]);
      end
    end
    assign bus.digit_value[4*gi +: 4] = value_reg[gi];
  end

  assign bus.oled_data    = oled_reg;
  assign bus.seg_state    = seg_reg;
  assign bus.digit_valid  = valid_reg;
  assign bus.result_valid = result_valid_reg;
endmodule

// File: tb/tb_oled_digit_canvas.sv
// Directed bench for oled_digit_canvas: two digits, BLINK_DIV=4, hand-computed expectations.
module tb_oled_digit_canvas;
  localparam int ND = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  oled_digit_canvas_if #(.NUM_DIGITS(ND)) bus ();

  oled_digit_canvas #(
    .NUM_DIGITS(ND), .DIGIT_X0(8), .DIGIT_Y0(3), .DIGIT_PITCH(26),
    .SEG_LEN(20), .SEG_THK(3), .BLINK_DIV(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic click(input logic [6:0] mx, input logic [5:0] my);
    bus.mouse_x    = mx;
    bus.mouse_y    = my;
    bus.mouse_left = 1'b1;
    repeat (3) tick();
    bus.mouse_left = 1'b0;
    repeat (3) tick();
    bus.mouse_x = 7'd90;
    bus.mouse_y = 6'd60;
  endtask

  task automatic pixel(input string tag, input logic [6:0] px, input logic [5:0] py,
                       input logic [15:0] exp);
    bus.x = px;
    bus.y = py;
    tick();
    check_val(tag, 32'(bus.oled_data), 32'(exp));
  endtask

  initial begin
    logic [15:0] blink_exp;
    bus.x = '0; bus.y = '0;
    bus.mouse_x = 7'd90; bus.mouse_y = 6'd60;
    bus.mouse_left = 1'b0; bus.submit = 1'b0; bus.clear = 1'b0;
    repeat (3) tick();
    check_val("rst_oled",  32'(bus.oled_data),    32'h0);
    check_val("rst_seg",   32'(bus.seg_state),    32'h0);
    check_val("rst_value", 32'(bus.digit_value),  32'hFF);
    check_val("rst_valid", 32'(bus.digit_valid),  32'h0);
    check_val("rst_rv",    32'(bus.result_valid), 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    // First click with exact latency: seg toggles at the third edge after the rise.
    bus.mouse_x = 7'd18; bus.mouse_y = 6'd4; bus.mouse_left = 1'b1;
    repeat (2) tick();
    check_val("click_lat_k1", 32'(bus.seg_state), 32'h0);
    tick();
    check_val("click_lat_k2", 32'(bus.seg_state), 32'h1);
    bus.mouse_left = 1'b0;
    repeat (3) tick();
    click(7'd18, 6'd4);
    check_val("click_a_off", 32'(bus.seg_state), 32'h0);
    click(7'd50, 6'd4);
    check_val("click_d1_a", 32'(bus.seg_state), 32'h80);
    click(7'd50, 6'd4);

    // Draw an 8 on digit 0.
    click(7'd18, 6'd4);  click(7'd27, 6'd13); click(7'd27, 6'd33); click(7'd18, 6'd42);
    click(7'd9,  6'd33); click(7'd9,  6'd13); click(7'd18, 6'd23);
    check_val("eight_seg",   32'(bus.seg_state),        32'h7F);
    check_val("eight_value", 32'(bus.digit_value[3:0]), 32'h8);
    check_val("eight_valid", 32'(bus.digit_valid[0]),   32'h1);
    click(7'd18, 6'd42);
    check_val("no_d_seg",   32'(bus.seg_state),        32'h77);
    check_val("no_d_value", 32'(bus.digit_value[3:0]), 32'hF);

    // Digit 0 -> 1, digit 1 -> 3.
    click(7'd18, 6'd4); click(7'd9, 6'd33); click(7'd9, 6'd13); click(7'd18, 6'd23);
    click(7'd44, 6'd4); click(7'd53, 6'd13); click(7'd53, 6'd33); click(7'd44, 6'd42);
    click(7'd44, 6'd23);
    check_val("13_seg",   32'(bus.seg_state),   32'({7'h4F, 7'h06}));
    check_val("13_value", 32'(bus.digit_value), 32'h31);
    check_val("13_valid", 32'(bus.digit_valid), 32'h3);
    pixel("pix_lit_edit", 7'd27, 6'd13, 16'hFFFF);
    pixel("pix_unlit",    7'd18, 6'd23, 16'h2104);
    pixel("pix_bg",       7'd0,  6'd0,  16'h0000);

    bus.submit = 1'b1;
    tick();
    bus.submit = 1'b0;
    check_val("lock_rv", 32'(bus.result_valid), 32'h1);
    pixel("pix_locked", 7'd27, 6'd13, 16'h07E0);
    click(7'd18, 6'd4);
    check_val("lock_click", 32'(bus.seg_state), 32'({7'h4F, 7'h06}));

    bus.clear = 1'b1; bus.submit = 1'b1;
    tick();
    bus.clear = 1'b0; bus.submit = 1'b0;
    check_val("clr_rv",  32'(bus.result_valid), 32'h0);
    check_val("clr_seg", 32'(bus.seg_state),    32'h0);

    // Digit 0 = 1, digit 1 = lone 'a' (invalid) -> ERROR blink on digit 1.
    click(7'd27, 6'd13); click(7'd27, 6'd33); click(7'd44, 6'd4);
    check_val("err_seg",   32'(bus.seg_state),   32'({7'h01, 7'h06}));
    check_val("err_valid", 32'(bus.digit_valid), 32'h1);
    bus.x = 7'd44; bus.y = 6'd4;
    bus.submit = 1'b1;
    tick();
    bus.submit = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i <= 4 || (i >= 9 && i <= 12)) blink_exp = 16'hF800;
      else if (i <= 16)                  blink_exp = 16'h0000;
      else                               blink_exp = 16'hFFFF;
      check_val($sformatf("blink_%0d", i), 32'(bus.oled_data), 32'(blink_exp));
    end
    check_val("err_keep_seg", 32'(bus.seg_state),    32'({7'h01, 7'h06}));
    check_val("err_rv",       32'(bus.result_valid), 32'h0);

    // Second ERROR: valid digit stays white, then asynchronous reset mid-ERROR.
    bus.x = 7'd27; bus.y = 6'd13;
    bus.submit = 1'b1;
    tick();
    bus.submit = 1'b0;
    tick();
    check_val("err_valid_white", 32'(bus.oled_data), 32'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_oled",  32'(bus.oled_data),    32'h0);
    check_val("arst_seg",   32'(bus.seg_state),    32'h0);
    check_val("arst_value", 32'(bus.digit_value),  32'hFF);
    check_val("arst_valid", 32'(bus.digit_valid),  32'h0);
    check_val("arst_rv",    32'(bus.result_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    bus.mouse_x = 7'd40; bus.mouse_y = 6'd30;
    pixel("cursor_on", 7'd40, 6'd30, 16'hF800);
    bus.mouse_x = 7'd100; bus.mouse_y = 6'd10;
    pixel("cursor_off", 7'd100, 6'd10, 16'h0000);
    click(7'd100, 6'd10);
    check_val("offscreen_click", 32'(bus.seg_state), 32'h0);
    click(7'd18, 6'd4);
    check_val("post_rst_click", 32'(bus.seg_state), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
